ncc_result_writer: RTL and testbench
====================================

# ncc_result_writer

Downstream of the per-set NCC search controller: captures each set's winning result (set index, best window index, 64-bit fixed-point log2 NCC), buffers it in a small FIFO, and writes it back to result memory as three 32-bit words over a req/grant write port. When the controller signals frame completion and every buffered result has been written, the block pulses `frame_written`, which lets the host read the result table.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: result entries buffered; power of two, at least 2.
- `RESULT_BASE`, 16'h4000: word address of the set 0 record.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `result_valid` in 1: one-cycle pulse; the result fields are valid this cycle.
- `set_idx` in 8: set number, 0..149.
- `window_index` in 9: best window index for the set.
- `ncc_log2` in 64: best NCC in log2, fixed-point [9:-54], raw bits.
- `frame_done_in` in 1: one-cycle pulse from the controller at the end of a frame.
- `mem_req` out 1: write request.
- `mem_wr` out 1: equals `mem_req` (write-only port).
- `mem_addr` out 16: word address.
- `mem_wdata` out 32: write data.
- `mem_gnt` in 1: the current word is accepted at this rising edge.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `overflow` out 1: sticky; a result was dropped.
- `frame_written` out 1: one-cycle pulse when the frame's results are committed.
- `sets_written` out 8: records fully written in the current frame.

## Operation
- **FIFO entry:** 81 bits, {set_idx, window_index, ncc_log2}.
  - A push happens on `result_valid` when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the result is dropped and `overflow` is set. `overflow` clears only on reset.
- **Record layout:** base address A = `RESULT_BASE` + {set_idx, 2'b00}. Offset 3 is never written.
  - Word 0 at A: {8'hA5, set_idx, 7'b0, window_index}.
  - Word 1 at A+1: ncc_log2[63:32].
  - Word 2 at A+2: ncc_log2[31:0].
- **FSM states:** IDLE, W0, W1, W2.
  - IDLE to W0 when the FIFO is not empty.
  - W0 to W1 on `mem_gnt`.
  - W1 to W2 on `mem_gnt`.
  - W2 on `mem_gnt`: pop the FIFO head and increment `sets_written`. Go to W0 if another entry remains after the pop, otherwise to IDLE.
  - With no grant the FSM holds its state; `mem_addr` and `mem_wdata` stay stable.
- **Write port outputs:**
  - `mem_req` is 1 in W0, W1 and W2.
  - `mem_addr` and `mem_wdata` are driven from the FIFO head and the current state.
  - In IDLE, `mem_addr` and `mem_wdata` are 0.
- **Frame completion:**
  - `frame_done_in` sets `pending_frame`. A repeat pulse while it is already set has no extra effect.
  - When state is IDLE, the FIFO is empty, `pending_frame`=1 and `result_valid`=0, assert `frame_written` for one cycle.
  - At the end of that cycle, clear `pending_frame` and `sets_written`. `sets_written` shows the frame's total during the pulse.
  - `sets_written` saturates at 255.
- **Reset:** asynchronous. It clears the FIFO, returns the FSM to IDLE, and clears `pending_frame`. An in-flight write is abandoned and `mem_req` drops immediately. All outputs go to 0.

## Timing
- **Reset values:**
  - `mem_req`, `mem_wr`, `fifo_full`, `overflow`, `frame_written`: 0.
  - `mem_addr`, `mem_wdata`, `sets_written`: 0.
- **Latency:**
  - `result_valid` in cycle t with the FIFO empty and state IDLE: the push lands at the end of cycle t.
  - The FSM enters W0 at the end of cycle t+1, so `mem_req` first goes high in cycle t+2.
  - With `mem_gnt` held at 1, words go out in t+2, t+3 and t+4. The pop lands at the end of t+4.
- **Throughput:** back-to-back entries give 3 cycles per record with no idle gap.
- **Flags:**
  - `fifo_full` is registered and reflects the count after this cycle's push/pop.
  - `overflow` rises the cycle after the drop.
- **Earliest `frame_written`:** the cycle after the last pop, or the cycle after `frame_done_in`, whichever is later.

## Test plan
- **Single record:** reset, keep `mem_gnt`=1, then `result_valid` with set_idx=5, window_index=9'h12A, ncc_log2=64'h0123_4567_89AB_CDEF.
  - Required: writes 16'h4014 = 32'hA505_012A, 16'h4015 = 32'h0123_4567, 16'h4016 = 32'h89AB_CDEF, in cycles t+2..t+4; `sets_written`=1.
- **Grant stalls:** 3 results on consecutive cycles; `mem_gnt` toggles 1,0,0,1,...
  - Required: addr/data hold stable while the grant is low; exactly 9 writes, in set order; no idle cycle between records.
- **Overflow:** `mem_gnt`=0, push 9 results with FIFO_DEPTH=8.
  - Required: `fifo_full`=1 after the 8th; the 9th is dropped and `overflow`=1.
  - Then raise `mem_gnt`: exactly 8 records are written, and `overflow` stays 1.
- **Simultaneous push/pop when full:** with the FIFO full, issue `result_valid` in the same cycle as the W2 grant.
  - Required: the new entry is accepted, the count stays 8, and `overflow` stays 0.
- **Frame completion:** pulse `frame_done_in` while 2 records are still queued.
  - Required: `frame_written` pulses once, the cycle after the final pop, with `sets_written`=150 for a 150-set frame; `sets_written` is 0 the next cycle.
- **Reset mid-write:** assert `rst_n`=0 during W1 with a stalled grant.
  - Required: `mem_req` drops immediately and all outputs go to 0. After release, a new result writes correctly starting from its W0 word.

Source files
------------

// File: rtl/ncc_result_writer.sv
// ncc_result_writer: buffers per-set NCC search results and writes each one
// back to result memory as a three-word record over a req/grant write port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   result_valid          one-cycle pulse qualifying set_idx/window_index/ncc_log2
//   set_idx[7:0]          set number of the result
//   window_index[8:0]     best window index for the set
//   ncc_log2[63:0]        best NCC, log2 fixed-point raw bits
//   frame_done_in         one-cycle end-of-frame pulse from the search controller
//   mem_req, mem_wr       write request (write-only port, so mem_wr == mem_req)
//   mem_addr[15:0]        word address of the current record word
//   mem_wdata[31:0]       data of the current record word
//   mem_gnt               current word accepted at this rising edge
//   fifo_full             FIFO holds FIFO_DEPTH entries
//   overflow              sticky: a result was dropped because the FIFO was full
//   frame_written         one-cycle pulse once the frame's results are committed
//   sets_written[7:0]     records fully written in the current frame (saturating)
module ncc_result_writer #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] RESULT_BASE = 16'h4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        result_valid,
    input  logic [7:0]  set_idx,
    input  logic [8:0]  window_index,
    input  logic [63:0] ncc_log2,
    input  logic        frame_done_in,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    output logic        fifo_full,
    output logic        overflow,
    output logic        frame_written,
    output logic [7:0]  sets_written
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, W0, W1, W2} state_t;

    state_t        state, state_nxt;
    logic [80:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nxt;
    logic          push, pop, pending_frame;
    logic [80:0]   head;
    logic [7:0]    head_set;
    logic [8:0]    head_win;
    logic [63:0]   head_ncc;
    logic [15:0]   rec_addr;
    logic [1:0]    word_off;

    // A full FIFO still accepts a result when the head is popped this cycle.
    assign pop       = (state == W2) && mem_gnt;
    assign push      = result_valid && (!fifo_full || pop);
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

    assign head     = fifo_mem[rd_ptr];
    assign head_set = head[80:73];
    assign head_win = head[72:64];
    assign head_ncc = head[63:0];
    assign rec_addr = RESULT_BASE + {6'd0, head_set, 2'b00};
    assign word_off = (state == W1) ? 2'd1 : (state == W2) ? 2'd2 : 2'd0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (|count) ? W0 : IDLE;
            W0:      state_nxt = mem_gnt ? W1 : W0;
            W1:      state_nxt = mem_gnt ? W2 : W1;
            // Chain straight into the next record when one remains after the pop.
            W2:      state_nxt = mem_gnt ? ((|count_nxt) ? W0 : IDLE) : W2;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req       = (state != IDLE);
        mem_wr        = mem_req;
        mem_addr      = (state == IDLE) ? 16'd0 : rec_addr + {14'd0, word_off};
        mem_wdata     = (state == W0) ? {8'hA5, head_set, 7'd0, head_win} :
                        (state == W1) ? head_ncc[63:32] :
                        (state == W2) ? head_ncc[31:0]  : 32'd0;
        // An empty FIFO implies IDLE; a same-cycle result defers the commit.
        frame_written = (state == IDLE) && !(|count) && pending_frame && !result_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_full     <= 1'b0;
            overflow      <= 1'b0;
            pending_frame <= 1'b0;
            sets_written  <= 8'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count         <= count_nxt;
            fifo_full     <= (count_nxt == DEPTH_C);
            overflow      <= overflow | (result_valid & ~push);
            // A new end-of-frame pulse coinciding with the commit is kept.
            pending_frame <= frame_done_in | (pending_frame & ~frame_written);
            sets_written  <= frame_written ? 8'd0 :
                             (pop && sets_written != 8'hFF) ? sets_written + 8'd1 :
                             sets_written;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {set_idx, window_index, ncc_log2};
    end
endmodule

// File: tb/tb_ncc_result_writer.sv
// tb_ncc_result_writer: randomized scoreboard bench for ncc_result_writer.
module tb_ncc_result_writer;
    localparam int DEPTH = 8;

    logic        clk, rst_n, result_valid, frame_done_in, mem_gnt;
    logic [7:0]  set_idx;
    logic [8:0]  window_index;
    logic [63:0] ncc_log2;
    logic        mem_req, mem_wr, fifo_full, overflow, frame_written;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  sets_written;

    ncc_result_writer #(.FIFO_DEPTH(DEPTH), .RESULT_BASE(16'h4000)) dut (
        .clk(clk), .rst_n(rst_n), .result_valid(result_valid), .set_idx(set_idx),
        .window_index(window_index), .ncc_log2(ncc_log2), .frame_done_in(frame_done_in),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .fifo_full(fifo_full), .overflow(overflow),
        .frame_written(frame_written), .sets_written(sets_written)
    );

    typedef struct {logic [15:0] a; logic [31:0] d; bit last;} wr_t;

    int  vectors = 0, miscompares = 0;
    wr_t exp_q[$];
    int  occ = 0, m_sets = 0, gnt_mode = 0, tog = 0, idle_run = 0;
    bit  pending = 0, m_ovf = 0, prev_stall = 0, prev_pop_more = 0, prev_occ0 = 1;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Grant generator: 0 low, 1 high, 2 pattern 1,0,0, 3 random (~75% high).
    initial begin
        mem_gnt = 0;
        forever begin
            @(posedge clk);
            #2;
            tog = (tog + 1) % 3;
            mem_gnt = (gnt_mode == 1) || (gnt_mode == 2 && tog == 0) ||
                      (gnt_mode == 3 && $urandom_range(0, 3) != 0);
        end
    end

    // Monitor / reference model: one transaction-level step per cycle.
    always @(negedge clk) begin
        bit pop, fw_exp;
        logic [15:0] a;
        if (!rst_n) begin
            chk("rst_mem_req", 64'(mem_req), 0);
            chk("rst_mem_wr", 64'(mem_wr), 0);
            chk("rst_mem_addr", 64'(mem_addr), 0);
            chk("rst_mem_wdata", 64'(mem_wdata), 0);
            chk("rst_fifo_full", 64'(fifo_full), 0);
            chk("rst_overflow", 64'(overflow), 0);
            chk("rst_frame_written", 64'(frame_written), 0);
            chk("rst_sets_written", 64'(sets_written), 0);
            exp_q.delete();
            occ = 0; m_sets = 0; pending = 0; m_ovf = 0;
            prev_stall = 0; prev_pop_more = 0; prev_occ0 = 1; idle_run = 0;
        end else begin
            fw_exp = (occ == 0) && pending && !result_valid;
            chk("frame_written", 64'(frame_written), 64'(fw_exp));
            chk("sets_written", 64'(sets_written), 64'(m_sets));
            chk("fifo_full", 64'(fifo_full), 64'(occ == DEPTH));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (mem_req) begin
                if (exp_q.size() == 0) fail("spurious_req");
                else begin
                    chk("mem_addr", 64'(mem_addr), 64'(exp_q[0].a));
                    chk("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].d));
                end
                if (prev_occ0) fail("req_too_early");
            end else begin
                chk("idle_addr", 64'(mem_addr), 0);
                chk("idle_wdata", 64'(mem_wdata), 0);
            end
            if (prev_stall) begin
                chk("stall_req", 64'(mem_req), 1);
                chk("stall_addr", 64'(mem_addr), 64'(prev_addr));
                chk("stall_wdata", 64'(mem_wdata), 64'(prev_data));
            end
            if (prev_pop_more) chk("no_gap", 64'(mem_req), 1);
            idle_run = (occ > 0 && !mem_req) ? idle_run + 1 : 0;
            if (idle_run > 1) fail("start_latency");
            prev_occ0 = (occ == 0);
            pop = 0;
            if (mem_req && mem_gnt && exp_q.size() > 0) begin
                pop = exp_q[0].last;
                void'(exp_q.pop_front());
            end
            prev_stall = mem_req && !mem_gnt;
            prev_addr = mem_addr;
            prev_data = mem_wdata;
            if (result_valid) begin
                if (occ < DEPTH || pop) begin
                    a = 16'h4000 + 16'(set_idx) * 16'd4;
                    exp_q.push_back('{a, {8'hA5, set_idx, 16'(window_index)}, 1'b0});
                    exp_q.push_back('{a + 16'd1, ncc_log2[63:32], 1'b0});
                    exp_q.push_back('{a + 16'd2, ncc_log2[31:0], 1'b1});
                    occ++;
                end else m_ovf = 1;
            end
            if (pop) begin
                occ--;
                m_sets = (m_sets < 255) ? m_sets + 1 : 255;
            end
            prev_pop_more = pop && (occ > 0);
            if (fw_exp) m_sets = 0;
            pending = frame_done_in || (pending && !fw_exp);
        end
    end

    task automatic step(input bit rv, input logic [7:0] s, input logic [8:0] w,
                        input logic [63:0] n, input bit fd);
        @(posedge clk);
        #1;
        result_valid = rv; set_idx = s; window_index = w; ncc_log2 = n; frame_done_in = fd;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic rnd_push(input logic [7:0] s);
        step(1, s, 9'($urandom), {$urandom, $urandom}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 0; result_valid = 0; frame_done_in = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic drain();
        int g = 0;
        while (occ != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        if (occ != 0) fail("drain_timeout");
        idle(2);
    endtask

    initial begin
        int g;
        rst_n = 0; result_valid = 0; frame_done_in = 0;
        set_idx = 0; window_index = 0; ncc_log2 = 0;
        do_reset();

        // Single record with exact cycle placement.
        gnt_mode = 1;
        idle(2);
        step(1, 8'd5, 9'h12A, 64'h0123_4567_89AB_CDEF, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk) chk("t1_no_req", 64'(mem_req), 0);
        @(negedge clk);
        chk("t2_req", 64'(mem_wr), 1);
        chk("t2_addr", 64'(mem_addr), 64'h4014);
        chk("t2_data", 64'(mem_wdata), 64'hA505_012A);
        @(negedge clk);
        chk("t3_addr", 64'(mem_addr), 64'h4015);
        chk("t3_data", 64'(mem_wdata), 64'h0123_4567);
        @(negedge clk);
        chk("t4_addr", 64'(mem_addr), 64'h4016);
        chk("t4_data", 64'(mem_wdata), 64'h89AB_CDEF);
        @(negedge clk) chk("t5_sets", 64'(sets_written), 1);
        drain();

        // Grant stalls, three back-to-back results.
        gnt_mode = 2;
        for (int i = 0; i < 3; i++) rnd_push(8'(10 + i));
        idle(1);
        drain();

        // Overflow with grant held low.
        do_reset();
        gnt_mode = 0;
        for (int i = 0; i < 8; i++) rnd_push(8'(20 + i));
        idle(1);
        chk("full_after_8", 64'(fifo_full), 1);
        rnd_push(8'd99);
        idle(1);
        chk("overflow_set", 64'(overflow), 1);
        gnt_mode = 1;
        drain();
        chk("overflow_sticky", 64'(overflow), 1);

        // Push into a full FIFO in the same cycle as the W2 grant.
        do_reset();
        gnt_mode = 0;
        for (int i = 0; i < 8; i++) rnd_push(8'(40 + i));
        idle(2);
        gnt_mode = 1;
        g = 0;
        do begin
            @(posedge clk);
            #1;
            g++;
        end while (!(mem_req && mem_addr[1:0] == 2'd2) && g < 30);
        if (g >= 30) fail("w2_wait");
        result_valid = 1; set_idx = 8'd77; window_index = 9'h1FF; ncc_log2 = {$urandom, $urandom};
        idle(1);
        chk("full_stays", 64'(fifo_full), 1);
        chk("no_overflow", 64'(overflow), 0);
        drain();

        // Frame completion on an empty FIFO.
        step(0, 0, 0, 0, 1);
        idle(3);

        // 150-set frame with random grants.
        gnt_mode = 3;
        for (int s = 0; s < 150; s++) begin
            g = 0;
            @(posedge clk);
            #1;
            result_valid = 0;
            while (fifo_full && g < 200) begin
                @(posedge clk);
                #1;
                g++;
            end
            result_valid = 1; set_idx = 8'(s); window_index = 9'($urandom);
            ncc_log2 = {$urandom, $urandom};
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!frame_written && g < 200);
        if (!frame_written) fail("frame_written_timeout");
        else begin
            chk("frame_total", 64'(sets_written), 150);
            @(negedge clk);
            chk("sets_cleared", 64'(sets_written), 0);
            chk("fw_single", 64'(frame_written), 0);
        end

        // Reset while W1 is stalled.
        do_reset();
        gnt_mode = 0;
        rnd_push(8'd3);
        idle(1);
        g = 0;
        while (!mem_req && g < 10) begin
            idle(1);
            g++;
        end
        gnt_mode = 1;
        idle(1);
        gnt_mode = 0;
        idle(2);
        chk("in_w1_addr", 64'(mem_addr), 64'h400D);
        rst_n = 0;
        #1;
        chk("rst_req_drop", 64'(mem_req), 0);
        chk("rst_addr_drop", 64'(mem_addr), 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        gnt_mode = 1;
        rnd_push(8'd149);
        idle(1);
        drain();

        // Randomized traffic with occasional frame ends.
        gnt_mode = 3;
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 2) == 0, 8'($urandom_range(0, 149)), 9'($urandom),
                 {$urandom, $urandom}, $urandom_range(0, 49) == 0);
        idle(1);
        drain();
        step(0, 0, 0, 0, 1);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
